// File: rtl/serial_link_credit_receiver_if.sv
// Link-receiver bundle: the incoming packet stream from the data-link layer
// plus the buffered data output towards the sink and the credit reporting
// signals towards the local sender.
//   master : packet source / sink side (drives rcv_*, ready_i)
//   slave  : the credit receiver (drives data_o/valid_o, credit outputs, fill/overflow)
interface serial_link_credit_receiver_if #(
  parameter type data_t     = logic [7:0],
  parameter type credit_t   = logic [3:0],
  parameter int  NumCredits = 8
);
  localparam int FillW = $clog2(NumCredits + 1);

  logic             rcv_valid_i;
  data_t            rcv_data_i;
  credit_t          rcv_credits_i;
  logic             rcv_cred_only_i;
  credit_t          credits_received_o;
  logic             receive_cred_o;
  data_t            data_o;
  logic             valid_o;
  logic             ready_i;
  credit_t          cred_released_o;
  logic [FillW-1:0] fill_o;
  logic             overflow_o;

  modport master (
    output rcv_valid_i, rcv_data_i, rcv_credits_i, rcv_cred_only_i, ready_i,
    input  credits_received_o, receive_cred_o, data_o, valid_o,
           cred_released_o, fill_o, overflow_o
  );

  modport slave (
    input  rcv_valid_i, rcv_data_i, rcv_credits_i, rcv_cred_only_i, ready_i,
    output credits_received_o, receive_cred_o, data_o, valid_o,
           cred_released_o, fill_o, overflow_o
  );
endinterface

// File: rtl/serial_link_credit_receiver.sv
// Receive side of the serial link credit flow control.
// Data packets are buffered in a NumCredits-deep FIFO (no fall-through);
// piggy-backed credits are forwarded to the local sender one cycle later;
// every freed receive slot (pop, or a credits-only packet which consumed
// CredOnlyConsCred slots at the remote end) is reported one cycle later.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   link          : packet input, FIFO output and credit reporting bundle
// WarnOverflow enables the "overflow never happens" warning check; benches
// that provoke overflow on purpose turn it off.
module serial_link_credit_receiver #(
  parameter type data_t           = logic [7:0],
  parameter type credit_t         = logic [3:0],
  parameter int  NumCredits       = 8,
  parameter int  CredOnlyConsCred = 1,
  parameter bit  WarnOverflow     = 1'b1
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  serial_link_credit_receiver_if.slave link
);
  localparam int FillW = $clog2(NumCredits + 1);
  localparam int PtrW  = (NumCredits > 1) ? $clog2(NumCredits) : 1;

  data_t            mem_q [NumCredits];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic             receive_cred_q, receive_cred_d;
  credit_t          credits_received_q, credits_received_d;
  credit_t          cred_released_q, cred_released_d;
  logic             full, pop, push_req, push;

  always_comb begin
    full     = (fill_q == FillW'(NumCredits));
    pop      = (fill_q != '0) & link.ready_i;
    push_req = link.rcv_valid_i & ~link.rcv_cred_only_i;
    // A pop in the same cycle frees the slot the push needs, even when full.
    push     = push_req & (~full | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(NumCredits - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(NumCredits - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    fill_d = fill_q + FillW'(push) - FillW'(pop);

    overflow_d = overflow_q | (push_req & ~push);

    // Credits are forwarded regardless of packet type or whether it was dropped.
    receive_cred_d     = link.rcv_valid_i & (link.rcv_credits_i != '0);
    credits_received_d = receive_cred_d ? link.rcv_credits_i : '0;

    cred_released_d = credit_t'(pop)
                    + ((link.rcv_valid_i & link.rcv_cred_only_i) ? credit_t'(CredOnlyConsCred)
                                                                  : credit_t'(0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      fill_q             <= '0;
      overflow_q         <= 1'b0;
      receive_cred_q     <= 1'b0;
      credits_received_q <= '0;
      cred_released_q    <= '0;
    end else begin
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      fill_q             <= fill_d;
      overflow_q         <= overflow_d;
      receive_cred_q     <= receive_cred_d;
      credits_received_q <= credits_received_d;
      cred_released_q    <= cred_released_d;
    end
  end

  // Storage needs no reset: data_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= link.rcv_data_i;
  end

  assign link.valid_o            = (fill_q != '0);
  assign link.data_o             = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign link.fill_o             = fill_q;
  assign link.overflow_o         = overflow_q;
  assign link.receive_cred_o     = receive_cred_q;
  assign link.credits_received_o = credits_received_q;
  assign link.cred_released_o    = cred_released_q;

  a_num_credits: assert property (@(posedge clk_i) NumCredits >= 2)
    else $error("NumCredits must be >= 2");
  a_cred_width: assert property (@(posedge clk_i)
    (CredOnlyConsCred + 1) < (1 << $bits(credit_t)))
    else $error("CredOnlyConsCred + 1 does not fit in credit_t");
  a_fill_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fill_q <= FillW'(NumCredits))
    else $error("FIFO occupancy above NumCredits");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !WarnOverflow || !(overflow_d && !overflow_q))
    else $warning("packet dropped: receive FIFO overflow");
endmodule

// File: tb/tb_serial_link_credit_receiver.sv
module tb_serial_link_credit_receiver;
  typedef logic [7:0] data_t;
  typedef logic [3:0] cred_t;
  typedef data_t dq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Per-DUT stimulus: index 0 -> NumCredits=8, index 1 -> NumCredits=5
  logic  v[2], co[2], rdy[2];
  data_t dat[2];
  cred_t cr[2];

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO content as a queue plus expected registered outputs
  dq_t   mq[2];
  bit    ovf[2];
  logic  rc_e[2];
  cred_t cr_e[2], rel_e[2];
  int    cap[2] = '{8, 5};
  data_t got5[$];
  int    relsum5 = 0;

  serial_link_credit_receiver_if #(.data_t(data_t), .credit_t(cred_t), .NumCredits(8)) if8 ();
  serial_link_credit_receiver_if #(.data_t(data_t), .credit_t(cred_t), .NumCredits(5)) if5 ();

  assign if8.rcv_valid_i = v[0];   assign if5.rcv_valid_i = v[1];
  assign if8.rcv_data_i = dat[0];  assign if5.rcv_data_i = dat[1];
  assign if8.rcv_credits_i = cr[0]; assign if5.rcv_credits_i = cr[1];
  assign if8.rcv_cred_only_i = co[0]; assign if5.rcv_cred_only_i = co[1];
  assign if8.ready_i = rdy[0];     assign if5.ready_i = rdy[1];

  serial_link_credit_receiver #(.data_t(data_t), .credit_t(cred_t), .NumCredits(8),
    .CredOnlyConsCred(1), .WarnOverflow(1'b0)) u_dut8 (.clk_i(clk), .rst_ni(rst_n), .link(if8));
  serial_link_credit_receiver #(.data_t(data_t), .credit_t(cred_t), .NumCredits(5),
    .CredOnlyConsCred(1), .WarnOverflow(1'b1)) u_dut5 (.clk_i(clk), .rst_ni(rst_n), .link(if5));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] ed;
      ed = (mq[d].size() > 0) ? 32'(mq[d][0]) : 32'd0;
      chk("valid_o", d, d == 0 ? 32'(if8.valid_o) : 32'(if5.valid_o), 32'(mq[d].size() > 0));
      chk("data_o", d, d == 0 ? 32'(if8.data_o) : 32'(if5.data_o), ed);
      chk("fill_o", d, d == 0 ? 32'(if8.fill_o) : 32'(if5.fill_o), 32'(mq[d].size()));
      chk("overflow_o", d, d == 0 ? 32'(if8.overflow_o) : 32'(if5.overflow_o), 32'(ovf[d]));
      chk("receive_cred_o", d, d == 0 ? 32'(if8.receive_cred_o) : 32'(if5.receive_cred_o), 32'(rc_e[d]));
      chk("credits_received_o", d, d == 0 ? 32'(if8.credits_received_o) : 32'(if5.credits_received_o), 32'(cr_e[d]));
      chk("cred_released_o", d, d == 0 ? 32'(if8.cred_released_o) : 32'(if5.cred_released_o), 32'(rel_e[d]));
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      ovf[d] = 1'b0; rc_e[d] = 1'b0; cr_e[d] = '0; rel_e[d] = '0;
    end
  endtask

  // One clock: advance the model on the current inputs, clock, then compare.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      bit pop;
      pop = (mq[d].size() > 0) && rdy[d];
      if (d == 1 && if5.valid_o && rdy[1]) got5.push_back(if5.data_o);
      rc_e[d]  = v[d] && (cr[d] != 0);
      cr_e[d]  = rc_e[d] ? cr[d] : '0;
      rel_e[d] = cred_t'(pop) + ((v[d] && co[d]) ? cred_t'(1) : cred_t'(0));
      if (pop) void'(mq[d].pop_front());
      if (v[d] && !co[d]) begin
        if (mq[d].size() < cap[d]) mq[d].push_back(dat[d]);
        else ovf[d] = 1'b1;
      end
    end
    @(posedge clk); #1;
    relsum5 += int'(if5.cred_released_o);
    check_all();
  endtask

  task automatic put(input int d, input logic pv, input logic pco, input data_t pd, input cred_t pc);
    v[d] = pv; co[d] = pco; dat[d] = pd; cr[d] = pc;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) put(d, 1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  initial begin
    int sent;
    idle();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    model_clear();
    #12;
    check_all();                       // reset state
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1) three back-to-back data packets with ready low, then drain
    put(0, 1, 0, 8'hA1, 0); step();
    chk("t1_valid_cycle1", 0, 32'(if8.valid_o), 1);
    put(0, 1, 0, 8'hB2, 0); step();
    put(0, 1, 0, 8'hC3, 0); step();
    idle(); step();
    chk("t1_fill", 0, 32'(if8.fill_o), 3);
    chk("t1_head_held", 0, 32'(if8.data_o), 32'h A1);
    rdy[0] = 1'b1;
    repeat (3) step();
    chk("t1_last_release", 0, 32'(if8.cred_released_o), 1);
    rdy[0] = 1'b0; step();

    // 2) credits-only packet carrying 5 credits
    put(0, 1, 0, 8'h5A, 0); step();
    put(0, 1, 1, 8'hFF, 5); step();
    chk("t2_recv", 0, 32'(if8.receive_cred_o), 1);
    chk("t2_credits", 0, 32'(if8.credits_received_o), 5);
    chk("t2_release", 0, 32'(if8.cred_released_o), 1);
    chk("t2_fill", 0, 32'(if8.fill_o), 1);
    idle(); step();

    // 3) pop and credits-only arrival in the same cycle
    rdy[0] = 1'b1; put(0, 1, 1, 8'h00, 0); step();
    chk("t3_release_sum", 0, 32'(if8.cred_released_o), 2);
    rdy[0] = 1'b0; idle(); step();
    chk("t3_release_once", 0, 32'(if8.cred_released_o), 0);

    // 4) full FIFO: push with pop accepted, push without pop dropped
    for (int i = 0; i < 8; i++) begin put(0, 1, 0, data_t'(8'h10 + i), 0); step(); end
    rdy[0] = 1'b1; put(0, 1, 0, 8'h99, 0); step();
    chk("t4_fill_full", 0, 32'(if8.fill_o), 8);
    chk("t4_no_ovf", 0, 32'(if8.overflow_o), 0);
    rdy[0] = 1'b0; put(0, 1, 0, 8'h77, 3); step();
    chk("t4_ovf", 0, 32'(if8.overflow_o), 1);
    chk("t4_cred_fwd", 0, 32'(if8.credits_received_o), 3);
    idle(); step();
    chk("t4_ovf_sticky", 0, 32'(if8.overflow_o), 1);
    rdy[0] = 1'b1; repeat (9) step();

    // random traffic on the 8-deep instance
    for (int i = 0; i < 40; i++) begin
      put(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          data_t'($urandom), cred_t'($urandom_range(0, 8)));
      rdy[0] = 1'($urandom_range(0, 1));
      step();
    end
    idle(); rdy[0] = 1'b1; repeat (10) step();
    rdy[0] = 1'b0;

    // 5) wrap on the 5-deep instance with random ready
    got5.delete(); relsum5 = 0; sent = 0;
    for (int i = 0; i < 300 && got5.size() < 12; i++) begin
      idle();
      if (sent < 12 && mq[1].size() < 5 && $urandom_range(0, 3) != 0) begin
        put(1, 1, 0, data_t'(sent), 0); sent++;
      end
      rdy[1] = 1'($urandom_range(0, 1));
      step();
    end
    idle(); rdy[1] = 1'b0; step();
    chk("t5_count", 1, 32'(got5.size()), 12);
    for (int k = 0; k < got5.size(); k++) chk("t5_order", 1, 32'(got5[k]), 32'(k));
    chk("t5_release_total", 1, 32'(relsum5), 12);

    // 6) async reset mid-stream with three entries buffered
    for (int i = 0; i < 3; i++) begin put(0, 1, 0, data_t'(8'hE0 + i), 2); step(); end
    idle();
    chk("t6_fill_before", 0, 32'(if8.fill_o), 3);
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("t6_valid_async", 0, 32'(if8.valid_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    put(0, 1, 0, 8'h42, 0); step();
    chk("t6_fill_after", 0, 32'(if8.fill_o), 1);
    chk("t6_data_after", 0, 32'(if8.data_o), 32'h42);
    idle(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
